// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer and its argmax scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int PROB_W    = 32;
    localparam int NUM_CLASS = 10;
    localparam int RESULT_W  = 4;

    // Reported when no valid winner exists (reset value, watchdog expiry)
    localparam logic [RESULT_W-1:0] RESULT_NONE = 4'd15;

    // One-hot sequencer states
    typedef enum logic [7:0] {
        S_IDLE = 8'b0000_0001,
        S_CONV = 8'b0000_0010,
        S_RELU = 8'b0000_0100,
        S_POOL = 8'b0000_1000,
        S_FC   = 8'b0001_0000,
        S_SCAN = 8'b0010_0000,
        S_DONE = 8'b0100_0000,
        S_ERR  = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/prob_argmax_serial.sv
// Latches NUM_CLASS scores and serially finds the index of the largest (ties -> lowest index).
// Latency: NUM_CLASS cycles after i_load; o_done is high during the final comparison cycle.
// Backpressure: none; a new i_load restarts the scan and discards any scan in flight.
module prob_argmax_serial #(
    parameter int PROB_W    = cnn_pkg::PROB_W,
    parameter int NUM_CLASS = cnn_pkg::NUM_CLASS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_load,
    input  logic [PROB_W*NUM_CLASS-1:0]   i_prob_flat,
    output logic                          o_done,
    output logic [cnn_pkg::RESULT_W-1:0]  o_best_idx
);
    import cnn_pkg::*;

    localparam logic [RESULT_W-1:0] LP_LAST = RESULT_W'(NUM_CLASS - 1);

    logic [NUM_CLASS-1:0][PROB_W-1:0] r_bank;
    logic [RESULT_W-1:0]              r_idx;
    logic [PROB_W-1:0]                r_best;
    logic [RESULT_W-1:0]              r_best_idx;
    logic                             r_run;
    logic [PROB_W-1:0]                w_cur;

    assign w_cur      = r_bank[r_idx];
    // The last comparison lands on the same edge the sequencer leaves SCAN,
    // so best_idx is final by the time the sequencer reads it in DONE.
    assign o_done     = r_run && (r_idx == LP_LAST);
    assign o_best_idx = r_best_idx;

    // Load the bank on i_load, then walk idx 0..NUM_CLASS-1 keeping the strict maximum
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bank     <= '0;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_run      <= 1'b0;
        end else if (i_load) begin
            r_bank <= i_prob_flat;
            r_idx  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            // idx 0 seeds best; afterwards only a strictly larger score wins
            if ((r_idx == '0) || (w_cur > r_best)) begin
                r_best     <= w_cur;
                r_best_idx <= r_idx;
            end
            if (r_idx == LP_LAST) begin
                r_run <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences one inference conv->relu->pool->fc->argmax and reports the winning class.
// Latency: 1 + sum(stage cycles) + 10 scan + 1 done cycle from start sample to result_valid.
// Backpressure: stage advances only on qualified layer done; watchdog or abort return to IDLE.
module cnn_layer_sequencer #(
    parameter int          PROB_W      = cnn_pkg::PROB_W,
    parameter int          NUM_CLASS   = cnn_pkg::NUM_CLASS,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_conv_done,
    input  logic                          i_relu_done,
    input  logic                          i_pool_done,
    input  logic                          i_fc_done,
    input  logic [PROB_W*NUM_CLASS-1:0]   i_prob_flat,
    output logic                          o_conv_enable,
    output logic                          o_relu_enable,
    output logic                          o_pool_enable,
    output logic                          o_fc_enable,
    output logic                          o_busy,
    output logic [cnn_pkg::RESULT_W-1:0]  o_result,
    output logic                          o_result_valid,
    output logic                          o_timeout_err
);
    import cnn_pkg::*;

    localparam bit          LP_WD_ON   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] LP_WD_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    state_t              r_state;
    logic                r_conv_en;
    logic                r_relu_en;
    logic                r_pool_en;
    logic                r_fc_en;
    logic                r_busy;
    logic [RESULT_W-1:0] r_result;
    logic                r_result_valid;
    logic                r_timeout_err;
    logic [31:0]         r_wd;

    state_t              w_next;
    logic                w_stage_done;
    logic                w_qual;
    logic                w_timeout;
    logic                w_load;
    logic                w_scan_done;
    logic [RESULT_W-1:0] w_best_idx;

    // A done seen in the first cycle of a stage (wd count 0) may be left over
    // from the previous run, so only later cycles can advance the stage.
    assign w_qual    = w_stage_done && (r_wd != '0);
    assign w_timeout = LP_WD_ON && (r_wd == LP_WD_LAST);
    assign w_load    = (r_state == S_FC) && (w_next == S_SCAN);

    // Select the done input that belongs to the current stage
    always_comb begin
        w_stage_done = 1'b0;
        case (r_state)
            S_CONV:  w_stage_done = i_conv_done;
            S_RELU:  w_stage_done = i_relu_done;
            S_POOL:  w_stage_done = i_pool_done;
            S_FC:    w_stage_done = i_fc_done;
            default: w_stage_done = 1'b0;
        endcase
    end

    // Next-state decision; abort outranks done and timeout
    always_comb begin
        w_next = r_state;
        if ((r_state != S_IDLE) && i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) w_next = S_CONV;
                S_CONV: if (w_timeout) w_next = S_ERR; else if (w_qual) w_next = S_RELU;
                S_RELU: if (w_timeout) w_next = S_ERR; else if (w_qual) w_next = S_POOL;
                S_POOL: if (w_timeout) w_next = S_ERR; else if (w_qual) w_next = S_FC;
                S_FC:   if (w_timeout) w_next = S_ERR; else if (w_qual) w_next = S_SCAN;
                S_SCAN: if (w_scan_done) w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                S_ERR:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Per-stage watchdog: cleared on every state change, saturates instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wd <= '0;
        end else if (w_next != r_state) begin
            r_wd <= '0;
        end else if (r_wd != '1) begin
            r_wd <= r_wd + 32'd1;
        end
    end

    // State register plus registered enables, busy and result reporting
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= S_IDLE;
            r_conv_en      <= 1'b0;
            r_relu_en      <= 1'b0;
            r_pool_en      <= 1'b0;
            r_fc_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= RESULT_NONE;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_conv_en      <= (w_next == S_CONV);
            r_relu_en      <= (w_next == S_RELU);
            r_pool_en      <= (w_next == S_POOL);
            r_fc_en        <= (w_next == S_FC);
            r_busy         <= (w_next != S_IDLE);
            r_result_valid <= 1'b0;
            if ((r_state == S_IDLE) && i_start) begin
                r_timeout_err <= 1'b0;
            end
            if (w_next == S_ERR) begin
                r_timeout_err <= 1'b1;
            end
            if ((r_state == S_DONE) && !i_abort) begin
                r_result       <= w_best_idx;
                r_result_valid <= 1'b1;
            end
            if ((r_state == S_ERR) && !i_abort) begin
                r_result       <= RESULT_NONE;
                r_result_valid <= 1'b1;
            end
        end
    end

    prob_argmax_serial #(
        .PROB_W    (PROB_W),
        .NUM_CLASS (NUM_CLASS)
    ) u_argmax (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_prob_flat (i_prob_flat),
        .o_done      (w_scan_done),
        .o_best_idx  (w_best_idx)
    );

    assign o_conv_enable  = r_conv_en;
    assign o_relu_enable  = r_relu_en;
    assign o_pool_enable  = r_pool_en;
    assign o_fc_enable    = r_fc_en;
    assign o_busy         = r_busy;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_timeout_err  = r_timeout_err;

endmodule
